ofs_plat_shim_ccip_mmio_csr_rsp: RTL
====================================

OFS_PLAT_SHIM_CCIP_MMIO_CSR_RSP -- requirements
Module: ofs_plat_shim_ccip_mmio_csr_rsp

Interface
REQ-001 SHALL have parameter NUM_CSRS, default 16: number of 64-bit CSRs; power of 2, 2..64.
REQ-002 SHALL have parameter RO_MASK, default 0 (NUM_CSRS bits): bit i set makes CSR i read-only, sourced from hw_status.
REQ-003 SHALL have parameter DFH_VALUE, default 64'h0: CSR 0 read value when the DFH feature is compiled in.
REQ-004 Ports, clock and reset first; one clock; reset is asynchronous and active-low:
  clk  in  1  sole clock
  reset_n  in  1  asynchronous active-low reset
  mmio_rd_valid  in  1  MMIO read request (CCI-P c0 mmioRdValid)
  mmio_wr_valid  in  1  MMIO write request (CCI-P c0 mmioWrValid)
  mmio_addr  in  16  address in 4-byte (DW) units
  mmio_len  in  2  0=4B, 1=8B; other values treated as 8B
  mmio_tid  in  9  read transaction ID
  mmio_wr_data  in  64  write data (low 64 bits of c0 data)
  rsp_valid  out  1  MMIO read response (CCI-P c2 mmioRdValid)
  rsp_tid  out  9  echoed transaction ID
  rsp_data  out  64  response data
  csr_q  out  NUM_CSRS*64  current CSR contents, CSR i at [64*i+63:64*i]
  csr_wr_pulse  out  NUM_CSRS  one-cycle strobe per CSR written by MMIO
  hw_status  in  NUM_CSRS*64  read value for read-only CSRs

Function
REQ-005 Decode: CSR index = mmio_addr[log2(NUM_CSRS):1]; mmio_addr[0] selects upper DW for 4B accesses; 8B accesses ignore mmio_addr[0].
REQ-006 Out-of-range: mmio_addr[15:log2(NUM_CSRS)+1] nonzero -> write ignored, read returns 64'h0 with normal latency and tid.
REQ-007 8B write to RW CSR: register takes mmio_wr_data at the next clk edge; 4B write: only the selected DW updated from mmio_wr_data[31:0].
REQ-008 Writes to read-only CSRs SHALL be dropped; csr_wr_pulse fires only for accepted writes, one cycle after the request, coincident with the updated csr_q.
REQ-009 Reads: two-stage pipeline; request in cycle T -> rsp_valid high exactly in cycle T+2 with the request's tid; one read accepted per cycle, no backpressure, no drops.
REQ-010 Read data is sampled in cycle T; a write in cycle T to the same CSR is NOT visible to a read in T, and IS visible to a read in T+1.
REQ-011 4B read response: selected DW replicated in rsp_data[31:0] and rsp_data[63:32]; 8B: full 64 bits.
REQ-012 Read-only CSR i returns hw_status slice i as sampled in cycle T.
REQ-013 Simultaneous mmio_rd_valid and mmio_wr_valid SHALL both be processed independently per REQ-007..010.
REQ-014 rsp_tid and rsp_data SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-015 On reset_n low: all RW CSRs 64'h0, rsp_valid 0, rsp_tid 0, rsp_data 0, csr_wr_pulse 0, pipeline emptied.
REQ-016 Reads in flight when reset asserts SHALL be discarded; no response after reset_n deasserts.
REQ-017 Requests in the first cycle after reset_n deasserts SHALL be accepted normally.

Configuration
REQ-018 Macro OFS_PLAT_CCIP_MMIO_DFH_EN defined: CSR 0 read-only, reads return DFH_VALUE, writes dropped with no csr_wr_pulse[0], csr_q[63:0] = DFH_VALUE.
REQ-019 Macro undefined: CSR 0 behaves per RO_MASK[0] like any other CSR; DFH_VALUE unused.

Verification
REQ-020 8B write addr 16'h0004 data 64'hDEAD_BEEF_0123_4567, then 8B read addr 16'h0004 tid 9'h05 -> csr_wr_pulse[2] one cycle; response at T+2, tid 5, data 64'hDEAD_BEEF_0123_4567.
REQ-021 4B write addr 16'h0007 data 32'hCAFE_F00D over CSR 3 = 0, 4B read addr 16'h0007 -> CSR 3 = 64'hCAFE_F00D_0000_0000; rsp_data 64'hCAFE_F00D_CAFE_F00D.
REQ-022 Reads back-to-back in 4 cycles, tids 1,2,3,4 -> rsp_valid four consecutive cycles, tids 1,2,3,4 in order.
REQ-023 Same-cycle write 64'h1 and read to CSR 5 (prior 0), then read next cycle -> first response 0, second response 64'h1.
REQ-024 RO_MASK bit 6 set, hw_status[6] = 64'hA5, write 64'hFF to CSR 6 -> no pulse; read returns 64'hA5; read addr 16'h0100 (NUM_CSRS=16) -> data 0.
REQ-025 With OFS_PLAT_CCIP_MMIO_DFH_EN, DFH_VALUE 64'h1000_0000_0000_0001: write CSR 0 then read -> 64'h1000_0000_0000_0001; reset asserted at T+1 of a read -> no rsp_valid.

Source files
------------

// File: rtl/ofs_plat_shim_ccip_mmio_csr_rsp.sv
// ofs_plat_shim_ccip_mmio_csr_rsp
//   MMIO-mapped bank of NUM_CSRS 64-bit CSRs behind a CCI-P style MMIO port.
//   Writes land at the next clock edge. Reads go through a fixed two-stage
//   pipeline: a request in cycle T produces its response in cycle T+2.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   mmio_rd_valid/mmio_wr_valid   read / write request strobes
//   mmio_addr[15:0]               DW (4-byte) address
//   mmio_len[1:0]                 0 = 4B access, anything else = 8B access
//   mmio_tid[8:0]                 read transaction ID
//   mmio_wr_data[63:0]            write data
//   rsp_valid/rsp_tid/rsp_data    read response (zero while rsp_valid is low)
//   csr_q[NUM_CSRS*64-1:0]        current CSR contents, CSR i at [64*i +: 64]
//   csr_wr_pulse[NUM_CSRS-1:0]    one-cycle strobe per accepted CSR write
//   hw_status[NUM_CSRS*64-1:0]    read value of read-only CSRs
//
// Optional feature macro: OFS_PLAT_CCIP_MMIO_DFH_EN
//   When defined, CSR 0 is a read-only device feature header returning DFH_VALUE.
module ofs_plat_shim_ccip_mmio_csr_rsp #(
    parameter int unsigned                NUM_CSRS  = 16,
    parameter logic [NUM_CSRS-1:0]        RO_MASK   = '0,
    parameter logic [63:0]                DFH_VALUE = 64'h0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mmio_rd_valid,
    input  logic                          mmio_wr_valid,
    input  logic [15:0]                   mmio_addr,
    input  logic [1:0]                    mmio_len,
    input  logic [8:0]                    mmio_tid,
    input  logic [63:0]                   mmio_wr_data,
    output logic                          rsp_valid,
    output logic [8:0]                    rsp_tid,
    output logic [63:0]                   rsp_data,
    output logic [NUM_CSRS*64-1:0]        csr_q,
    output logic [NUM_CSRS-1:0]           csr_wr_pulse,
    input  logic [NUM_CSRS*64-1:0]        hw_status
);

    localparam int unsigned IDX_W = $clog2(NUM_CSRS);
    localparam int unsigned TID_W = 9;
    localparam int unsigned DAT_W = 64;

`ifdef OFS_PLAT_CCIP_MMIO_DFH_EN
    localparam bit DFH_EN = 1'b1;
`else
    localparam bit DFH_EN = 1'b0;
`endif

    // CSR 0 joins the read-only set when the feature header is compiled in
    localparam logic [NUM_CSRS-1:0] RO_EFF = RO_MASK | {{(NUM_CSRS-1){1'b0}}, DFH_EN};

    logic [DAT_W-1:0]  csr_mem_q [NUM_CSRS];
    logic [DAT_W-1:0]  csr_mem_d [NUM_CSRS];
    logic [DAT_W-1:0]  hw_arr    [NUM_CSRS];
    logic [NUM_CSRS-1:0] wr_pulse_q, wr_pulse_d;

    logic              s1_valid_q, s1_valid_d;
    logic [TID_W-1:0]  s1_tid_q,   s1_tid_d;
    logic [DAT_W-1:0]  s1_data_q,  s1_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [TID_W-1:0]  rsp_tid_q,   rsp_tid_d;
    logic [DAT_W-1:0]  rsp_data_q,  rsp_data_d;

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              len8;
    logic [DAT_W-1:0]  rd_word;
    logic [31:0]       rd_dw;
    logic [DAT_W-1:0]  rd_data;

    assign idx      = mmio_addr[IDX_W:1];
    assign in_range = (mmio_addr[15:IDX_W+1] == '0);
    assign len8     = (mmio_len != 2'd0);

    // Flat bus <-> per-CSR array views
    for (genvar i = 0; i < NUM_CSRS; i++) begin : g_csr
        assign hw_arr[i] = hw_status[64*i +: 64];
        if (i == 0) begin : g_csr0
            assign csr_q[63:0] = DFH_EN ? DFH_VALUE : csr_mem_q[0];
        end else begin : g_csrn
            assign csr_q[64*i +: 64] = csr_mem_q[i];
        end
    end

    // Write decode: accepted writes update storage and raise the matching strobe
    always_comb begin
        for (int i = 0; i < NUM_CSRS; i++) csr_mem_d[i] = csr_mem_q[i];
        wr_pulse_d = '0;
        if (mmio_wr_valid && in_range && !RO_EFF[idx]) begin
            if (len8) begin
                csr_mem_d[idx] = mmio_wr_data;
            end else if (mmio_addr[0]) begin
                csr_mem_d[idx][63:32] = mmio_wr_data[31:0];
            end else begin
                csr_mem_d[idx][31:0] = mmio_wr_data[31:0];
            end
            wr_pulse_d[idx] = 1'b1;
        end
    end

    // Read data is taken from pre-write storage in the request cycle
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (DFH_EN && (idx == '0)) begin
                rd_word = DFH_VALUE;
            end else if (RO_EFF[idx]) begin
                rd_word = hw_arr[idx];
            end else begin
                rd_word = csr_mem_q[idx];
            end
        end
        rd_dw   = mmio_addr[0] ? rd_word[63:32] : rd_word[31:0];
        rd_data = len8 ? rd_word : {rd_dw, rd_dw};
    end

    // Two-stage response pipeline; payload forced to zero on idle slots
    always_comb begin
        s1_valid_d  = mmio_rd_valid;
        s1_tid_d    = mmio_rd_valid ? mmio_tid : '0;
        s1_data_d   = mmio_rd_valid ? rd_data  : '0;
        rsp_valid_d = s1_valid_q;
        rsp_tid_d   = s1_tid_q;
        rsp_data_d  = s1_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CSRS; i++) csr_mem_q[i] <= '0;
            wr_pulse_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_tid_q    <= '0;
            s1_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CSRS; i++) csr_mem_q[i] <= csr_mem_d[i];
            wr_pulse_q  <= wr_pulse_d;
            s1_valid_q  <= s1_valid_d;
            s1_tid_q    <= s1_tid_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_tid      = rsp_tid_q;
    assign rsp_data     = rsp_data_q;
    assign csr_wr_pulse = wr_pulse_q;

endmodule
